fpga_cfg_loader: RTL and testbench

FPGA_CFG_LOADER -- requirements
Module: fpga_cfg_loader

---
 rtl/fpga_cfg_pkg.sv | 15 +
 rtl/crc16_serial.sv | 26 ++
 rtl/fpga_cfg_loader.sv | 174 +++++++++++++++++
 tb/tb_fpga_cfg_loader.sv | 451 ++++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/fpga_cfg_pkg.sv
// Shared definitions for the FPGA configuration loader: FSM encoding and CRC constants.
package fpga_cfg_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StVerifyConn,
        StVerifyClb,
        StCheck
    } cfg_state_e;

    localparam logic [15:0] CRC_POLY = 16'h1021;
    localparam logic [15:0] CRC_INIT = 16'hFFFF;

endpackage

// File: rtl/crc16_serial.sv
// Bit-serial CRC-16-CCITT; clear loads the init value, en folds in one bit.
module crc16_serial
    import fpga_cfg_pkg::*;
(
    input  logic        clk,
    input  logic        rst_n,
    input  logic        clear,
    input  logic        en,
    input  logic        din,
    output logic [15:0] crc
);

    logic fb;
    assign fb = crc[15] ^ din;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            crc <= '0;
        end else if (clear) begin
            crc <= CRC_INIT;
        end else if (en) begin
            crc <= {crc[14:0], 1'b0} ^ (fb ? CRC_POLY : 16'h0000);
        end
    end

endmodule

// File: rtl/fpga_cfg_loader.sv
// Streams host config words into the connection and CLB scan chains, then reads both
// chains back by recirculation and compares the readback CRC against the load CRC.
module fpga_cfg_loader
    import fpga_cfg_pkg::*;
#(
    parameter int unsigned CONN_CHAIN_LEN = 256,
    parameter int unsigned CLB_CHAIN_LEN  = 64,
    parameter int unsigned CFG_WORD_WIDTH = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic                      start,
    input  logic [CFG_WORD_WIDTH-1:0] cfg_data,
    input  logic                      cfg_valid,
    output logic                      cfg_ready,
    output logic                      conn_scan_in,
    output logic                      conn_scan_en,
    input  logic                      conn_scan_out,
    output logic                      clb_scan_in,
    output logic                      clb_scan_en,
    input  logic                      clb_scan_out,
    output logic                      busy,
    output logic                      cfg_done,
    output logic                      cfg_err
);

    localparam int unsigned TOTAL = CONN_CHAIN_LEN + CLB_CHAIN_LEN;
    localparam int unsigned CW    = $clog2(TOTAL + 1);
    localparam int unsigned WW    = $clog2(CFG_WORD_WIDTH + 1);

    localparam logic [CW-1:0] CONN_LEN_C  = CW'(CONN_CHAIN_LEN);
    localparam logic [CW-1:0] LOAD_LAST_C = CW'(TOTAL - 1);
    localparam logic [CW-1:0] CONN_LAST_C = CW'(CONN_CHAIN_LEN - 1);
    localparam logic [CW-1:0] CLB_LAST_C  = CW'(CLB_CHAIN_LEN - 1);
    localparam logic [WW-1:0] WORD_BITS_C = WW'(CFG_WORD_WIDTH);

    cfg_state_e                state_q, state_d;
    logic [CFG_WORD_WIDTH-1:0] sreg_q, sreg_d;
    logic [WW-1:0]             wcnt_q, wcnt_d;
    logic [CW-1:0]             cnt_q, cnt_d;
    logic                      done_q, done_d;
    logic                      err_q, err_d;

    logic        crc_clear;
    logic        load_crc_en, rb_crc_en, rb_din;
    logic [15:0] crc_load, crc_rb;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= StIdle;
            sreg_q  <= '0;
            wcnt_q  <= '0;
            cnt_q   <= '0;
            done_q  <= 1'b0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            sreg_q  <= sreg_d;
            wcnt_q  <= wcnt_d;
            cnt_q   <= cnt_d;
            done_q  <= done_d;
            err_q   <= err_d;
        end
    end

    always_comb begin
        state_d      = state_q;
        sreg_d       = sreg_q;
        wcnt_d       = wcnt_q;
        cnt_d        = cnt_q;
        done_d       = done_q;
        err_d        = err_q;
        cfg_ready    = 1'b0;
        conn_scan_in = 1'b0;
        conn_scan_en = 1'b0;
        clb_scan_in  = 1'b0;
        clb_scan_en  = 1'b0;
        crc_clear    = 1'b0;
        load_crc_en  = 1'b0;
        rb_crc_en    = 1'b0;
        rb_din       = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (start) begin
                    state_d   = StLoad;
                    done_d    = 1'b0;
                    err_d     = 1'b0;
                    cnt_d     = '0;
                    wcnt_d    = '0;
                    crc_clear = 1'b1;
                end
            end
            StLoad: begin
                cfg_ready = (wcnt_q == '0);
                if (wcnt_q == '0) begin
                    if (cfg_valid) begin
                        sreg_d = cfg_data;
                        wcnt_d = WORD_BITS_C;
                    end
                end else begin
                    load_crc_en = 1'b1;
                    if (cnt_q < CONN_LEN_C) begin
                        conn_scan_en = 1'b1;
                        conn_scan_in = sreg_q[CFG_WORD_WIDTH-1];
                    end else begin
                        clb_scan_en = 1'b1;
                        clb_scan_in = sreg_q[CFG_WORD_WIDTH-1];
                    end
                    sreg_d = sreg_q << 1;
                    wcnt_d = wcnt_q - WW'(1);
                    cnt_d  = cnt_q + CW'(1);
                    // Final chain bit: leftover word bits are dropped by emptying the register.
                    if (cnt_q == LOAD_LAST_C) begin
                        state_d = StVerifyConn;
                        wcnt_d  = '0;
                        cnt_d   = '0;
                    end
                end
            end
            StVerifyConn: begin
                conn_scan_en = 1'b1;
                conn_scan_in = conn_scan_out;
                rb_crc_en    = 1'b1;
                rb_din       = conn_scan_out;
                cnt_d        = cnt_q + CW'(1);
                if (cnt_q == CONN_LAST_C) begin
                    state_d = StVerifyClb;
                    cnt_d   = '0;
                end
            end
            StVerifyClb: begin
                clb_scan_en = 1'b1;
                clb_scan_in = clb_scan_out;
                rb_crc_en   = 1'b1;
                rb_din      = clb_scan_out;
                cnt_d       = cnt_q + CW'(1);
                if (cnt_q == CLB_LAST_C) begin
                    state_d = StCheck;
                    cnt_d   = '0;
                end
            end
            StCheck: begin
                done_d  = 1'b1;
                err_d   = (crc_rb != crc_load);
                state_d = StIdle;
            end
            default: state_d = StIdle;
        endcase
    end

    assign busy     = (state_q != StIdle);
    assign cfg_done = done_q;
    assign cfg_err  = err_q;

    crc16_serial u_crc_load (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (crc_clear),
        .en    (load_crc_en),
        .din   (sreg_q[CFG_WORD_WIDTH-1]),
        .crc   (crc_load)
    );

    crc16_serial u_crc_rb (
        .clk   (clk),
        .rst_n (rst_n),
        .clear (crc_clear),
        .en    (rb_crc_en),
        .din   (rb_din),
        .crc   (crc_rb)
    );

endmodule

// File: tb/tb_fpga_cfg_loader.sv
// Bench for fpga_cfg_loader: two instances (10/6/4 and 5/4/4) driving behavioural scan chains.
module tb_fpga_cfg_loader;

    localparam int unsigned CA = 10;
    localparam int unsigned LA = 6;
    localparam int unsigned CB = 5;
    localparam int unsigned LB = 4;
    localparam int unsigned W  = 4;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    int pass_cnt = 0;
    int tot_cnt  = 0;

    logic [W-1:0] words[$];
    bit           exp_bits[$];

    // Instance A
    logic          start_a = 1'b0, valid_a = 1'b0;
    logic [W-1:0]  data_a = '0;
    logic          ready_a, conn_in_a, conn_en_a, clb_in_a, clb_en_a, busy_a, done_a, err_a;
    logic [CA-1:0] conn_ch_a = '0;
    logic [LA-1:0] clb_ch_a = '0;
    logic [LA-1:0] flip_mask_a = '0;
    logic          flip_arm_a = 1'b0, flip_ack_a = 1'b0;
    bit            conn_log_a[$], clb_log_a[$];
    int            both_en_a = 0, idle_en_a = 0;

    // Instance B
    logic          start_b = 1'b0, valid_b = 1'b0;
    logic [W-1:0]  data_b = '0;
    logic          ready_b, conn_in_b, conn_en_b, clb_in_b, clb_en_b, busy_b, done_b, err_b;
    logic [CB-1:0] conn_ch_b = '0;
    logic [LB-1:0] clb_ch_b = '0;
    bit            conn_log_b[$], clb_log_b[$];
    int            both_en_b = 0;

    fpga_cfg_loader #(
        .CONN_CHAIN_LEN (CA),
        .CLB_CHAIN_LEN  (LA),
        .CFG_WORD_WIDTH (W)
    ) u_dut_a (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start_a),
        .cfg_data      (data_a),
        .cfg_valid     (valid_a),
        .cfg_ready     (ready_a),
        .conn_scan_in  (conn_in_a),
        .conn_scan_en  (conn_en_a),
        .conn_scan_out (conn_ch_a[CA-1]),
        .clb_scan_in   (clb_in_a),
        .clb_scan_en   (clb_en_a),
        .clb_scan_out  (clb_ch_a[LA-1]),
        .busy          (busy_a),
        .cfg_done      (done_a),
        .cfg_err       (err_a)
    );

    fpga_cfg_loader #(
        .CONN_CHAIN_LEN (CB),
        .CLB_CHAIN_LEN  (LB),
        .CFG_WORD_WIDTH (W)
    ) u_dut_b (
        .clk           (clk),
        .rst_n         (rst_n),
        .start         (start_b),
        .cfg_data      (data_b),
        .cfg_valid     (valid_b),
        .cfg_ready     (ready_b),
        .conn_scan_in  (conn_in_b),
        .conn_scan_en  (conn_en_b),
        .conn_scan_out (conn_ch_b[CB-1]),
        .clb_scan_in   (clb_in_b),
        .clb_scan_en   (clb_en_b),
        .clb_scan_out  (clb_ch_b[LB-1]),
        .busy          (busy_b),
        .cfg_done      (done_b),
        .cfg_err       (err_b)
    );

    // Scan chain models: first bit shifted in ends up at the tail after a full load.
    always @(posedge clk) begin
        if (conn_en_a) begin
            conn_ch_a <= {conn_ch_a[CA-2:0], conn_in_a};
            conn_log_a.push_back(conn_in_a);
        end
        if (clb_en_a) begin
            clb_ch_a <= {clb_ch_a[LA-2:0], clb_in_a};
            clb_log_a.push_back(clb_in_a);
        end else if (flip_arm_a != flip_ack_a) begin
            clb_ch_a   <= clb_ch_a ^ flip_mask_a;
            flip_ack_a <= flip_arm_a;
        end
        if (conn_en_a && clb_en_a) both_en_a <= both_en_a + 1;
        if ((conn_en_a || clb_en_a) && !busy_a) idle_en_a <= idle_en_a + 1;
    end

    always @(posedge clk) begin
        if (conn_en_b) begin
            conn_ch_b <= {conn_ch_b[CB-2:0], conn_in_b};
            conn_log_b.push_back(conn_in_b);
        end
        if (clb_en_b) begin
            clb_ch_b <= {clb_ch_b[LB-2:0], clb_in_b};
            clb_log_b.push_back(clb_in_b);
        end
        if (conn_en_b && clb_en_b) both_en_b <= both_en_b + 1;
    end

    // Reference: the word stream MSB first, truncated to the total chain length.
    task automatic build_exp(input int total);
        exp_bits.delete();
        foreach (words[k]) begin
            for (int i = W - 1; i >= 0; i--) begin
                if (exp_bits.size() < total) exp_bits.push_back(words[k][i]);
            end
        end
    endtask

    function automatic logic [15:0] crc_model();
        logic [15:0] c = 16'hFFFF;
        logic        fb;
        foreach (exp_bits[i]) begin
            fb = c[15] ^ exp_bits[i];
            c  = {c[14:0], 1'b0};
            if (fb) c = c ^ 16'h1021;
        end
        return c;
    endfunction

    task automatic test_reset();
        rst_n = 1'b0;
        #1;
        tot_cnt++;
        if ({ready_a, conn_in_a, conn_en_a, clb_in_a, clb_en_a, busy_a, done_a, err_a} !== 8'h00)
            $display("FAIL reset_a outputs got %b want 00000000",
                     {ready_a, conn_in_a, conn_en_a, clb_in_a, clb_en_a, busy_a, done_a, err_a});
        else pass_cnt++;
        tot_cnt++;
        if ({ready_b, conn_in_b, conn_en_b, clb_in_b, clb_en_b, busy_b, done_b, err_b} !== 8'h00)
            $display("FAIL reset_b outputs got %b want 00000000",
                     {ready_b, conn_in_b, conn_en_b, clb_in_b, clb_en_b, busy_b, done_b, err_b});
        else pass_cnt++;
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
    endtask

    // Full load/verify on instance A with optional CLB bit corruption before readback.
    task automatic load_a(input string name, input int gap_max, input bit do_flip,
                          input int flip_pos);
        int            cb, lb, cyc;
        logic [CA-1:0] w_conn, g_conn_ld, g_conn_vf;
        logic [LA-1:0] w_clb, g_clb_ld, g_clb_vf, mask;
        cb   = conn_log_a.size();
        lb   = clb_log_a.size();
        mask = do_flip ? LA'(1) << flip_pos : '0;
        build_exp(CA + LA);
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        tot_cnt++;
        if ({busy_a, done_a, err_a} !== 3'b100)
            $display("FAIL %s start busy/done/err got %b want 100", name, {busy_a, done_a, err_a});
        else pass_cnt++;
        foreach (words[k]) begin
            valid_a = 1'b1;
            data_a  = words[k];
            cyc     = 0;
            while (!ready_a && cyc < 200) begin
                @(negedge clk);
                cyc++;
            end
            if (cyc >= 200) begin
                tot_cnt++;
                $display("FAIL %s ready_timeout word %0d got no ready want ready", name, k);
            end
            @(negedge clk);
            valid_a = 1'b0;
            data_a  = W'($urandom);
            repeat ($urandom_range(0, gap_max)) @(negedge clk);
        end
        if (do_flip) begin
            cyc = 0;
            while (clb_log_a.size() < lb + LA && cyc < 200) begin
                @(negedge clk);
                cyc++;
            end
            flip_mask_a = mask;
            flip_arm_a  = ~flip_arm_a;
        end
        cyc = 0;
        while (!done_a && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        tot_cnt++;
        if ({done_a, busy_a} !== 2'b10)
            $display("FAIL %s done/busy got %b want 10", name, {done_a, busy_a});
        else pass_cnt++;
        tot_cnt++;
        if (err_a !== do_flip) $display("FAIL %s cfg_err got %b want %b", name, err_a, do_flip);
        else pass_cnt++;
        g_conn_ld = 'x; g_conn_vf = 'x; g_clb_ld = 'x; g_clb_vf = 'x;
        for (int i = 0; i < CA; i++) begin
            w_conn[CA-1-i] = exp_bits[i];
            if (cb + i < conn_log_a.size()) g_conn_ld[CA-1-i] = conn_log_a[cb+i];
            if (cb + CA + i < conn_log_a.size()) g_conn_vf[CA-1-i] = conn_log_a[cb+CA+i];
        end
        for (int i = 0; i < LA; i++) begin
            w_clb[LA-1-i] = exp_bits[CA+i];
            if (lb + i < clb_log_a.size()) g_clb_ld[LA-1-i] = clb_log_a[lb+i];
            if (lb + LA + i < clb_log_a.size()) g_clb_vf[LA-1-i] = clb_log_a[lb+LA+i];
        end
        tot_cnt++;
        if (g_conn_ld !== w_conn)
            $display("FAIL %s conn_load got %b want %b", name, g_conn_ld, w_conn);
        else pass_cnt++;
        tot_cnt++;
        if (g_clb_ld !== w_clb) $display("FAIL %s clb_load got %b want %b", name, g_clb_ld, w_clb);
        else pass_cnt++;
        tot_cnt++;
        if (g_conn_vf !== w_conn)
            $display("FAIL %s conn_readback got %b want %b", name, g_conn_vf, w_conn);
        else pass_cnt++;
        tot_cnt++;
        if (g_clb_vf !== (w_clb ^ mask))
            $display("FAIL %s clb_readback got %b want %b", name, g_clb_vf, w_clb ^ mask);
        else pass_cnt++;
        tot_cnt++;
        if ({conn_ch_a, clb_ch_a} !== {w_conn, w_clb ^ mask})
            $display("FAIL %s chains_after got %b want %b", name, {conn_ch_a, clb_ch_a},
                     {w_conn, w_clb ^ mask});
        else pass_cnt++;
        tot_cnt++;
        if ((conn_log_a.size() - cb) != 2 * CA || (clb_log_a.size() - lb) != 2 * LA)
            $display("FAIL %s shift_counts got %0d/%0d want %0d/%0d", name,
                     conn_log_a.size() - cb, clb_log_a.size() - lb, 2 * CA, 2 * LA);
        else pass_cnt++;
        tot_cnt++;
        if (u_dut_a.crc_load !== crc_model())
            $display("FAIL %s crc_load got %h want %h", name, u_dut_a.crc_load, crc_model());
        else pass_cnt++;
    endtask

    task automatic test_vector();
        words = '{4'hA, 4'h5, 4'hF, 4'h0};
        load_a("vector", 0, 1'b0, 0);
    endtask

    task automatic test_flip();
        words = '{4'hA, 4'h5, 4'hF, 4'h0};
        load_a("flip", 1, 1'b1, int'($urandom_range(0, LA - 1)));
    endtask

    task automatic test_random();
        for (int n = 0; n < 4; n++) begin
            words.delete();
            repeat (4) words.push_back(W'($urandom));
            load_a($sformatf("random%0d", n), 3, 1'($urandom_range(0, 1)),
                   int'($urandom_range(0, LA - 1)));
        end
    endtask

    // Instance B: chains shorter than the stream, so the tail of the last word is dropped.
    task automatic test_discard();
        int            cb, lb, cyc;
        logic [CB-1:0] w_conn, g_conn;
        logic [LB-1:0] w_clb, g_clb;
        words = '{4'hF, 4'h0, 4'h8};
        build_exp(CB + LB);
        cb = conn_log_b.size();
        lb = clb_log_b.size();
        @(negedge clk);
        start_b = 1'b1;
        @(negedge clk);
        start_b = 1'b0;
        foreach (words[k]) begin
            valid_b = 1'b1;
            data_b  = words[k];
            cyc     = 0;
            while (!ready_b && cyc < 200) begin
                @(negedge clk);
                cyc++;
            end
            if (cyc >= 200) begin
                tot_cnt++;
                $display("FAIL discard ready_timeout word %0d got no ready want ready", k);
            end
            @(negedge clk);
            valid_b = 1'b0;
        end
        cyc = 0;
        while (!done_b && cyc < 500) begin
            @(negedge clk);
            cyc++;
        end
        g_conn = 'x;
        g_clb  = 'x;
        for (int i = 0; i < CB; i++) begin
            w_conn[CB-1-i] = exp_bits[i];
            if (cb + i < conn_log_b.size()) g_conn[CB-1-i] = conn_log_b[cb+i];
        end
        for (int i = 0; i < LB; i++) begin
            w_clb[LB-1-i] = exp_bits[CB+i];
            if (lb + i < clb_log_b.size()) g_clb[LB-1-i] = clb_log_b[lb+i];
        end
        tot_cnt++;
        if ({done_b, err_b, busy_b} !== 3'b100)
            $display("FAIL discard done/err/busy got %b want 100", {done_b, err_b, busy_b});
        else pass_cnt++;
        tot_cnt++;
        if ({g_conn, g_clb} !== 9'b111100001)
            $display("FAIL discard load_bits got %b want %b", {g_conn, g_clb}, 9'b111100001);
        else pass_cnt++;
        tot_cnt++;
        if ({conn_ch_b, clb_ch_b} !== {w_conn, w_clb})
            $display("FAIL discard chains_after got %b want %b", {conn_ch_b, clb_ch_b},
                     {w_conn, w_clb});
        else pass_cnt++;
        tot_cnt++;
        if ((conn_log_b.size() - cb) != 2 * CB || (clb_log_b.size() - lb) != 2 * LB)
            $display("FAIL discard en_cycles got %0d/%0d want %0d/%0d",
                     conn_log_b.size() - cb, clb_log_b.size() - lb, 2 * CB, 2 * LB);
        else pass_cnt++;
        tot_cnt++;
        if (u_dut_b.crc_load !== crc_model())
            $display("FAIL discard crc_load got %h want %h", u_dut_b.crc_load, crc_model());
        else pass_cnt++;
    endtask

    // cfg_valid held high throughout; stray start pulses while busy must be ignored.
    task automatic test_back_to_back();
        int cyc, k, overlap, bad_gap;
        bit pend;
        int rdy_at[$];
        words.delete();
        repeat (4) words.push_back(W'($urandom));
        build_exp(CA + LA);
        overlap = 0;
        bad_gap = 0;
        k       = 0;
        pend    = 1'b0;
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        valid_a = 1'b1;
        data_a  = words[0];
        cyc     = 0;
        while (cyc < 500) begin
            if (pend) begin
                k++;
                if (k < 4) data_a = words[k];
                pend = 1'b0;
            end
            if (ready_a) begin
                rdy_at.push_back(cyc);
                pend = 1'b1;
            end
            if (ready_a && (conn_en_a || clb_en_a)) overlap++;
            @(negedge clk);
            cyc++;
            start_a = 1'b0;
            if (done_a) break;
            start_a = ($urandom_range(0, 2) == 0);
        end
        start_a = 1'b0;
        valid_a = 1'b0;
        for (int i = 1; i < rdy_at.size(); i++) begin
            if (rdy_at[i] - rdy_at[i-1] != W + 1) bad_gap++;
        end
        tot_cnt++;
        if (rdy_at.size() != 4) $display("FAIL b2b ready_pulses got %0d want 4", rdy_at.size());
        else pass_cnt++;
        tot_cnt++;
        if (bad_gap != 0) $display("FAIL b2b ready_spacing got %0d bad gaps want 0", bad_gap);
        else pass_cnt++;
        tot_cnt++;
        if (overlap != 0) $display("FAIL b2b ready_while_shift got %0d want 0", overlap);
        else pass_cnt++;
        tot_cnt++;
        if ({done_a, err_a} !== 2'b10) $display("FAIL b2b done/err got %b want 10", {done_a, err_a});
        else pass_cnt++;
        tot_cnt++;
        if (u_dut_a.crc_load !== crc_model())
            $display("FAIL b2b crc_load got %h want %h", u_dut_a.crc_load, crc_model());
        else pass_cnt++;
        repeat (3) @(negedge clk);
        tot_cnt++;
        if ({busy_a, done_a} !== 2'b01)
            $display("FAIL b2b no_restart busy/done got %b want 01", {busy_a, done_a});
        else pass_cnt++;
    endtask

    task automatic test_reset_mid();
        int cyc;
        words = '{4'hA, 4'h5, 4'hF, 4'h0};
        @(negedge clk);
        start_a = 1'b1;
        @(negedge clk);
        start_a = 1'b0;
        for (int k = 0; k < 2; k++) begin
            valid_a = 1'b1;
            data_a  = words[k];
            cyc     = 0;
            while (!ready_a && cyc < 200) begin
                @(negedge clk);
                cyc++;
            end
            @(negedge clk);
        end
        valid_a = 1'b0;
        @(posedge clk);
        #2 rst_n = 1'b0;
        #1;
        tot_cnt++;
        if ({ready_a, conn_in_a, conn_en_a, clb_in_a, clb_en_a, busy_a, done_a, err_a} !== 8'h00)
            $display("FAIL reset_mid outputs got %b want 00000000",
                     {ready_a, conn_in_a, conn_en_a, clb_in_a, clb_en_a, busy_a, done_a, err_a});
        else pass_cnt++;
        @(negedge clk);
        rst_n = 1'b1;
        load_a("after_reset", 2, 1'b0, 0);
    endtask

    initial begin
        test_reset();
        test_vector();
        test_flip();
        test_random();
        test_discard();
        test_back_to_back();
        test_reset_mid();
        @(negedge clk);
        tot_cnt++;
        if (both_en_a != 0 || both_en_b != 0)
            $display("FAIL both_scan_en got %0d/%0d want 0/0", both_en_a, both_en_b);
        else pass_cnt++;
        tot_cnt++;
        if (idle_en_a != 0) $display("FAIL scan_en_when_idle got %0d want 0", idle_en_a);
        else pass_cnt++;
        $display("%0d/%0d checks passed", pass_cnt, tot_cnt);
        $finish;
    end

endmodule
